// File: rtl/sha256_pkg.sv
// Shared types and constants for the sha256 message feeder slice.
package sha256_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned MAX_WORDS_DEF = 127;
  localparam int unsigned WS_W          = 7;

  typedef enum logic [1:0] {
    FILL,
    SEND,
    DRAIN,
    WAIT_HASH
  } feeder_state_e;

endpackage

// File: rtl/sha256_byte_packer.sv
// Packs bytes MSB-first into a 32-bit word; reports completion, the word and its byte count.
module sha256_byte_packer
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  input  logic              i_last,
  output logic              o_pack_done,
  output logic [WORD_W-1:0] o_pack_word,
  output logic [2:0]        o_pack_nbytes
);

  logic [1:0]        r_byte_cnt;
  logic [WORD_W-1:0] r_pack;
  logic [WORD_W-1:0] w_word;

  // Merge the incoming byte into its slot; untouched low bytes stay zero.
  always_comb begin
    w_word = r_pack;
    unique case (r_byte_cnt)
      2'd0:    w_word[31:24] = i_byte;
      2'd1:    w_word[23:16] = i_byte;
      2'd2:    w_word[15:8]  = i_byte;
      default: w_word[7:0]   = i_byte;
    endcase
  end

  assign o_pack_done   = i_accept && ((r_byte_cnt == 2'd3) || i_last);
  assign o_pack_word   = w_word;
  assign o_pack_nbytes = {1'b0, r_byte_cnt} + 3'd1;

  // Byte counter and pack register; both clear once a word is handed off.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_byte_cnt <= 2'd0;
      r_pack     <= '0;
    end else if (i_accept) begin
      if (o_pack_done) begin
        r_byte_cnt <= 2'd0;
        r_pack     <= '0;
      end else begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_pack     <= w_word;
      end
    end
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// Byte-stream to sha256 word-interface driver with message truncation and hash wait.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last,
  input  logic              core_ready,
  output logic [2:0]        last_bytes,
  input  logic              hash_valid,
  output logic [WS_W-1:0]   words_sent,
  output logic              msg_done,
  output logic              overflow
);

  feeder_state_e     r_state;
  feeder_state_e     w_state_next;
  logic [WORD_W-1:0] r_word_data;
  logic              r_word_valid;
  logic              r_word_last;
  logic              r_forced;
  logic [2:0]        r_last_bytes;
  logic [WS_W-1:0]   r_words_sent;
  logic              r_msg_done;
  logic              r_overflow;

  logic              w_accept;
  logic              w_pack_done;
  logic [WORD_W-1:0] w_pack_word;
  logic [2:0]        w_pack_nbytes;
  logic              w_at_limit;

  // Only FILL feeds the packer; bytes taken in DRAIN are discarded.
  assign w_accept   = in_valid && (r_state == FILL);
  assign w_at_limit = (r_words_sent == WS_W'(MAX_WORDS - 1));

  sha256_byte_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .i_accept      (w_accept),
    .i_byte        (in_byte),
    .i_last        (in_last),
    .o_pack_done   (w_pack_done),
    .o_pack_word   (w_pack_word),
    .o_pack_nbytes (w_pack_nbytes)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= FILL;
    else      r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:      if (w_pack_done) w_state_next = SEND;
      SEND: begin
        if (core_ready) begin
          if (!r_word_last)  w_state_next = FILL;
          else if (r_forced) w_state_next = DRAIN;
          else               w_state_next = WAIT_HASH;
        end
      end
      DRAIN:     if (in_valid && in_last) w_state_next = WAIT_HASH;
      WAIT_HASH: if (hash_valid) w_state_next = FILL;
      default:   w_state_next = FILL;
    endcase
  end

  // Combinational outputs.
  always_comb begin
    in_ready = (r_state == FILL) || (r_state == DRAIN);
  end

  // Word, counter and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_word_last  <= 1'b0;
      r_forced     <= 1'b0;
      r_last_bytes <= 3'd0;
      r_words_sent <= '0;
      r_msg_done   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_msg_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_pack_done) begin
            r_word_data  <= w_pack_word;
            r_word_valid <= 1'b1;
            r_word_last  <= in_last || w_at_limit;
            // Truncation only when the limit, not the source, ended the message.
            r_forced     <= w_at_limit && !in_last;
            r_last_bytes <= w_pack_nbytes;
          end
        end
        SEND: begin
          if (core_ready) begin
            r_words_sent <= r_words_sent + 1'b1;
            r_word_valid <= 1'b0;
            if (r_word_last && r_forced) r_overflow <= 1'b1;
          end
        end
        WAIT_HASH: begin
          if (hash_valid) begin
            r_msg_done   <= 1'b1;
            r_words_sent <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign word_data  = r_word_data;
  assign word_valid = r_word_valid;
  assign word_last  = r_word_last;
  assign last_bytes = r_last_bytes;
  assign words_sent = r_words_sent;
  assign msg_done   = r_msg_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Self-checking bench for sha256_msg_feeder with a small word limit to exercise truncation.
module tb_sha256_msg_feeder;

  localparam int TB_MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_last;
  logic        core_ready;
  logic [2:0]  last_bytes;
  logic        hash_valid;
  logic [6:0]  words_sent;
  logic        msg_done;
  logic        overflow;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [7:0]  msg [64];
  logic        ovf_exp   = 1'b0;

  always #5 clk = ~clk;

  sha256_msg_feeder #(.MAX_WORDS(TB_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_last  (word_last),
    .core_ready (core_ready),
    .last_bytes (last_bytes),
    .hash_valid (hash_valid),
    .words_sent (words_sent),
    .msg_done   (msg_done),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: message of n bytes split into big-endian words, cut at TB_MAX words.
  // mode 0: core always ready, 1: random stalls, 2: exactly three stall cycles per word.
  task automatic run_msg(input int n, input int mode);
    int          nw, ns, k, idx, cyc, stall;
    logic [31:0] ew [32];
    logic        el [32];
    logic [2:0]  eb [32];
    logic        held, cr;
    logic [31:0] hd;
    logic        hl;
    logic [2:0]  hb;
    nw = (n + 3) / 4;
    ns = (nw > TB_MAX) ? TB_MAX : nw;
    if (nw > TB_MAX) ovf_exp = 1'b1;
    for (int w = 0; w < ns; w++) begin
      ew[w] = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) ew[w][31 - 8 * b -: 8] = msg[4 * w + b];
      eb[w] = (n - 4 * w >= 4) ? 3'd4 : 3'(n - 4 * w);
      el[w] = (w == ns - 1);
    end
    k = 0; idx = 0; cyc = 0; stall = 0; held = 1'b0;
    hd = '0; hl = 1'b0; hb = '0;
    forever begin
      @(negedge clk);
      if (k == ns && idx == n) break;
      cyc++;
      if (cyc > 500) begin
        chk("timeout", 32'd0, 32'd1);
        break;
      end
      if (word_valid) begin
        chk("in_ready_send", in_ready, 1'b0);
        if (held) begin
          chk("hold_data", word_data, hd);
          chk("hold_last", word_last, hl);
          chk("hold_lbytes", last_bytes, hb);
        end else begin
          stall = 0;
        end
        case (mode)
          0:       cr = 1'b1;
          1:       cr = ($urandom_range(0, 2) != 0);
          default: cr = (stall >= 3);
        endcase
        core_ready = cr;
        if (cr) begin
          if (k < ns) begin
            chk("word_data", word_data, ew[k]);
            chk("word_last", word_last, el[k]);
            chk("last_bytes", last_bytes, eb[k]);
          end else begin
            chk("extra_word", 32'd1, 32'd0);
          end
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = word_data; hl = word_last; hb = last_bytes;
          stall++;
        end
      end else begin
        core_ready = 1'($urandom_range(0, 1));
        held = 1'b0;
      end
      if (in_ready && idx < n) begin
        in_valid = 1'b1;
        in_byte  = msg[idx];
        in_last  = (idx == n - 1);
        idx++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_byte  = 8'($urandom);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; core_ready = 1'b0;
    chk("words_sent_end", words_sent, 32'(ns));
    chk("in_ready_wait", in_ready, 1'b0);
    chk("word_valid_end", word_valid, 1'b0);
    chk("overflow", overflow, ovf_exp);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("in_ready_wait", in_ready, 1'b0);
      chk("msg_done_idle", msg_done, 1'b0);
    end
    hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    chk("msg_done_pulse", msg_done, 1'b1);
    chk("words_sent_clr", words_sent, 32'd0);
    chk("in_ready_fill", in_ready, 1'b1);
    @(negedge clk);
    chk("msg_done_once", msg_done, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_byte = 8'h0; in_valid = 1'b0; in_last = 1'b0;
    core_ready = 1'b0; hash_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_word_valid", word_valid, 1'b0);
    chk("rst_word_data", word_data, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b1;

    // hash_valid while filling must be ignored
    @(negedge clk);
    hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    chk("hv_fill_done", msg_done, 1'b0);
    chk("hv_fill_ready", in_ready, 1'b1);
    chk("hv_fill_sent", words_sent, 32'd0);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 0);

    for (int i = 0; i < 8; i++) msg[i] = 8'(i + 1);
    run_msg(8, 2);

    for (int i = 0; i < 12; i++) msg[i] = 8'(8'hA0 + i);
    run_msg(12, 0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      run_msg(n, 1);
    end

    // Reset while a word is pending in SEND
    core_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_byte = 8'($urandom); in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", word_valid, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ovf_exp = 1'b0;
    chk("mrst_word_valid", word_valid, 1'b0);
    chk("mrst_word_data", word_data, 32'h0);
    chk("mrst_word_last", word_last, 1'b0);
    chk("mrst_last_bytes", last_bytes, 3'd0);
    chk("mrst_words_sent", words_sent, 32'd0);
    chk("mrst_msg_done", msg_done, 1'b0);
    chk("mrst_overflow", overflow, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 1);

    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      run_msg(n, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
